scoreboard_requester: RTL and testbench
=======================================

Name: scoreboard_requester

Overview:
Initiator side of the scoreboard request/ack protocol. It accepts lookup, insert and remove commands from the issuer, and processor-completion events from the proc array. It serialises them into single-cycle scoreboard strobes (write/read/flush/flush_val), holds the entry stable until ack, and returns the result. This lets the issuer and the completion logic share one scoreboard without violating its one-outstanding-request rule.

Parameters:
PROC_COUNT, `PROC_COUNT, number of processors; width of the completion vector and of proc ids.
TIMEOUT, 64, cycles to wait in WAIT for o_ack before aborting; must exceed PROC_COUNT+4.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_req_valid  in  1  issuer command valid
o_req_ready  out  1  command accepted when valid&&ready
i_req_op  in  2  0=LOOKUP(read), 1=INSERT(write), 2=REMOVE(flush by cmd_id), 3=reserved (ignored, accepted, no scoreboard access, rsp with exists=0)
i_req_entry  in  entry_t  cmd_id/proc_id for the command
i_proc_done  in  PROC_COUNT  one-cycle pulse per processor finishing; bit n => flush_val with proc_id n
o_sb_entry  out  entry_t  entry driven to scoreboard
o_sb_write / o_sb_read / o_sb_flush / o_sb_flush_val  out  1 each  scoreboard strobes
i_sb_ack  in  1  scoreboard result valid
i_sb_exists  in  1  scoreboard found flag
i_sb_id  in  $clog2(PROC_COUNT)  scoreboard proc id
o_rsp_valid  out  1  one-cycle issuer response
o_rsp_exists  out  1  key found (LOOKUP/REMOVE); 1 for INSERT on ack
o_rsp_proc_id  out  $clog2(PROC_COUNT)  proc id from scoreboard (LOOKUP)
o_rsp_timeout  out  1  command aborted by timeout
o_free_valid  out  1  one-cycle completion-flush done
o_free_proc_id  out  $clog2(PROC_COUNT)  proc id flushed
o_free_found  out  1  scoreboard held an entry for that proc

Behaviour:
- One clock; reset is synchronous and active-high. On i_rst: state=IDLE, pending mask=0, timeout counter=0, all strobes/valids/flags=0, o_sb_entry=0, ids=0. Reset mid-WAIT aborts silently: no response, pending completions lost.
- Pending mask: bit n set on i_proc_done[n]; cleared when its FLUSH_VAL is issued. A set and a clear on the same bit in the same cycle leave the bit set (new event wins).
- o_req_ready = (state==IDLE) && (pending==0) && !i_rst. Completions have strict priority over issuer commands.
- FSM: IDLE -> ISSUE -> WAIT -> IDLE.
  - IDLE: if pending!=0, select the lowest set bit n, latch entry {cmd_id=0, proc_id=n}, kind=FREE, go ISSUE. Else if valid&&ready and op!=3, latch i_req_entry and op, go ISSUE. Op 3 gives o_rsp_valid the next cycle with exists=0 and stays IDLE.
  - ISSUE: exactly one strobe high for exactly this cycle (INSERT->write, LOOKUP->read, REMOVE->flush, FREE->flush_val). Then go WAIT with counter=0.
  - WAIT: o_sb_entry held stable; all strobes 0. On i_sb_ack, capture exists/id. Next cycle pulse o_rsp_valid (issuer kinds) or o_free_valid (FREE), then return to IDLE. If the counter reaches TIMEOUT-1 without ack, pulse the response with timeout=1 and exists=0 (o_free_found=0 for FREE).
  - An ack and the timeout in the same cycle: the ack wins and timeout=0.
- o_sb_entry is held from ISSUE through the ack cycle inclusive, and is also held in IDLE (last value).
- Latency: strobe is 1 cycle after acceptance. With a scoreboard ack k cycles after the strobe (k>=2), the response is k+1 cycles after the strobe. Back-to-back: the next strobe is no earlier than 2 cycles after the ack, so the scoreboard is IDLE when sampled.
- i_sb_ack outside WAIT is ignored.
- Response outputs are valid only during their valid pulse and are 0 otherwise.

Test Plan:
- Reset, then INSERT {cmd_id=5, proc_id=2}: o_sb_write is high for exactly 1 cycle; model acks 2 cycles later; o_rsp_valid=1 and exists=1 one cycle after the ack. o_req_ready returns to 1 the next cycle.
- LOOKUP cmd_id=5 with the model returning exists=1, id=2 -> o_rsp_exists=1, o_rsp_proc_id=2. LOOKUP cmd_id=9 with exists=0 -> o_rsp_exists=0.
- i_proc_done=4'b1010 while the issuer holds valid: two flush_val strobes with proc_id 1 then 3; o_free_valid twice with ids 1 and 3; the issuer command is accepted only after both.
- Pulse i_proc_done[1] in the same cycle its FLUSH_VAL strobe issues -> a second flush_val for proc 1 follows.
- Model never acks a REMOVE -> after TIMEOUT=64 cycles in WAIT, o_rsp_valid=1, o_rsp_timeout=1, exists=0. Ack arriving on the 64th cycle -> timeout=0.
- Assert i_rst during WAIT -> next cycle all outputs 0, pending=0, no response pulse; a later ack is ignored.

Source files
------------

// File: rtl/scoreboard_requester.sv
// Initiator side of the scoreboard request/ack protocol: serialises issuer commands and
// processor-completion flushes into single-cycle scoreboard strobes, one outstanding at a time.
package scoreboard_requester_pkg;
    localparam int PROC_COUNT = 4;
    localparam int CMD_ID_W  = 8;
    localparam int PROC_ID_W = (PROC_COUNT > 1) ? $clog2(PROC_COUNT) : 1;

    typedef struct packed {
        logic [CMD_ID_W-1:0]  cmd_id;
        logic [PROC_ID_W-1:0] proc_id;
    } entry_t;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_INSERT = 2'd1,
        OP_REMOVE = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    // FREE shares the encoding of the reserved op, which never reaches ISSUE.
    typedef enum logic [1:0] {
        K_LOOKUP = 2'd0,
        K_INSERT = 2'd1,
        K_REMOVE = 2'd2,
        K_FREE   = 2'd3
    } kind_e;
endpackage

module scoreboard_requester
    import scoreboard_requester_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [1:0]            i_req_op,
    input  entry_t                i_req_entry,
    input  logic [PROC_COUNT-1:0] i_proc_done,
    output entry_t                o_sb_entry,
    output logic                  o_sb_write,
    output logic                  o_sb_read,
    output logic                  o_sb_flush,
    output logic                  o_sb_flush_val,
    input  logic                  i_sb_ack,
    input  logic                  i_sb_exists,
    input  logic [PROC_ID_W-1:0]  i_sb_id,
    output logic                  o_rsp_valid,
    output logic                  o_rsp_exists,
    output logic [PROC_ID_W-1:0]  o_rsp_proc_id,
    output logic                  o_rsp_timeout,
    output logic                  o_free_valid,
    output logic [PROC_ID_W-1:0]  o_free_proc_id,
    output logic                  o_free_found
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

    state_e                state_q;
    kind_e                 kind_q;
    entry_t                entry_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [PROC_COUNT-1:0] pending_q, pending_d, clr_mask;
    logic [PROC_ID_W-1:0]  sel_id;
    logic                  write_q, read_q, flush_q, flush_val_q;
    logic                  rsp_valid_q, rsp_exists_q, rsp_timeout_q;
    logic [PROC_ID_W-1:0]  rsp_proc_id_q;
    logic                  free_valid_q, free_found_q;
    logic [PROC_ID_W-1:0]  free_proc_id_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sel_id = '0;
        for (int n = PROC_COUNT - 1; n >= 0; n--) begin
            if (pending_q[n]) sel_id = PROC_ID_W'(n);
        end
    end

    // A completion arriving while its own flush issues must survive the clear.
    always_comb begin
        clr_mask = '0;
        if (state_q == S_ISSUE && kind_q == K_FREE) clr_mask[entry_q.proc_id] = 1'b1;
        pending_d = (pending_q & ~clr_mask) | i_proc_done;
    end

    assign o_req_ready = (state_q == S_IDLE) && (pending_q == '0) && !i_rst;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= S_IDLE;
            kind_q         <= K_LOOKUP;
            entry_q        <= '0;
            cnt_q          <= '0;
            pending_q      <= '0;
            write_q        <= 1'b0;
            read_q         <= 1'b0;
            flush_q        <= 1'b0;
            flush_val_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_exists_q   <= 1'b0;
            rsp_proc_id_q  <= '0;
            rsp_timeout_q  <= 1'b0;
            free_valid_q   <= 1'b0;
            free_proc_id_q <= '0;
            free_found_q   <= 1'b0;
        end else begin
            pending_q      <= pending_d;
            write_q        <= 1'b0;
            read_q         <= 1'b0;
            flush_q        <= 1'b0;
            flush_val_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_exists_q   <= 1'b0;
            rsp_proc_id_q  <= '0;
            rsp_timeout_q  <= 1'b0;
            free_valid_q   <= 1'b0;
            free_proc_id_q <= '0;
            free_found_q   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (pending_q != '0) begin
                        entry_q     <= '{cmd_id: '0, proc_id: sel_id};
                        kind_q      <= K_FREE;
                        flush_val_q <= 1'b1;
                        state_q     <= S_ISSUE;
                    end else if (i_req_valid) begin
                        if (op_e'(i_req_op) == OP_RSVD) begin
                            rsp_valid_q <= 1'b1;
                        end else begin
                            entry_q <= i_req_entry;
                            kind_q  <= kind_e'(i_req_op);
                            read_q  <= (op_e'(i_req_op) == OP_LOOKUP);
                            write_q <= (op_e'(i_req_op) == OP_INSERT);
                            flush_q <= (op_e'(i_req_op) == OP_REMOVE);
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_sb_ack || cnt_q == CNT_LAST) begin
                        state_q <= S_IDLE;
                        if (kind_q == K_FREE) begin
                            free_valid_q   <= 1'b1;
                            free_proc_id_q <= entry_q.proc_id;
                            free_found_q   <= i_sb_ack && i_sb_exists;
                        end else begin
                            rsp_valid_q   <= 1'b1;
                            rsp_timeout_q <= !i_sb_ack;
                            rsp_exists_q  <= i_sb_ack && (kind_q == K_INSERT || i_sb_exists);
                            rsp_proc_id_q <= i_sb_ack ? i_sb_id : '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_sb_entry     = entry_q;
    assign o_sb_write     = write_q;
    assign o_sb_read      = read_q;
    assign o_sb_flush     = flush_q;
    assign o_sb_flush_val = flush_val_q;
    assign o_rsp_valid    = rsp_valid_q;
    assign o_rsp_exists   = rsp_exists_q;
    assign o_rsp_proc_id  = rsp_proc_id_q;
    assign o_rsp_timeout  = rsp_timeout_q;
    assign o_free_valid   = free_valid_q;
    assign o_free_proc_id = free_proc_id_q;
    assign o_free_found   = free_found_q;
endmodule

// File: tb/tb_scoreboard_requester.sv
// Scoreboard bench for scoreboard_requester: directed commands and completions, a scripted
// scoreboard responder, and a monitor that pops expected strobes/responses as the DUT emits them.
module tb_scoreboard_requester;
    import scoreboard_requester_pkg::*;

    localparam int TIMEOUT = 64;

    logic                  i_clk = 1'b0;
    logic                  i_rst;
    logic                  i_req_valid;
    logic                  o_req_ready;
    logic [1:0]            i_req_op;
    entry_t                i_req_entry;
    logic [PROC_COUNT-1:0] i_proc_done;
    entry_t                o_sb_entry;
    logic                  o_sb_write, o_sb_read, o_sb_flush, o_sb_flush_val;
    logic                  i_sb_ack, i_sb_exists;
    logic [PROC_ID_W-1:0]  i_sb_id;
    logic                  o_rsp_valid, o_rsp_exists, o_rsp_timeout;
    logic [PROC_ID_W-1:0]  o_rsp_proc_id;
    logic                  o_free_valid, o_free_found;
    logic [PROC_ID_W-1:0]  o_free_proc_id;

    scoreboard_requester #(.TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_op(i_req_op), .i_req_entry(i_req_entry),
        .i_proc_done(i_proc_done),
        .o_sb_entry(o_sb_entry), .o_sb_write(o_sb_write), .o_sb_read(o_sb_read),
        .o_sb_flush(o_sb_flush), .o_sb_flush_val(o_sb_flush_val),
        .i_sb_ack(i_sb_ack), .i_sb_exists(i_sb_exists), .i_sb_id(i_sb_id),
        .o_rsp_valid(o_rsp_valid), .o_rsp_exists(o_rsp_exists),
        .o_rsp_proc_id(o_rsp_proc_id), .o_rsp_timeout(o_rsp_timeout),
        .o_free_valid(o_free_valid), .o_free_proc_id(o_free_proc_id),
        .o_free_found(o_free_found)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { int delay; logic ex; logic [PROC_ID_W-1:0] id; } plan_t;
    typedef struct { logic [3:0] strb; entry_t entry; int cyc; } strb_t;
    typedef struct { bit is_free; logic ex; logic [PROC_ID_W-1:0] id; logic to; int lat; } rsp_t;

    plan_t plan_q[$];
    strb_t strb_q[$];
    rsp_t  rsp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    last_strobe_cyc = 0;

    always @(posedge i_clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic entry_t mk(input int cmd, input int pid);
        entry_t e;
        e.cmd_id  = CMD_ID_W'(cmd);
        e.proc_id = PROC_ID_W'(pid);
        return e;
    endfunction

    task automatic plan(input int delay, input logic ex, input int id);
        plan_q.push_back('{delay: delay, ex: ex, id: PROC_ID_W'(id)});
    endtask

    task automatic exp_free(input int pid, input logic found, input int lat);
        strb_q.push_back('{strb: 4'b0001, entry: mk(0, pid), cyc: -1});
        rsp_q.push_back('{is_free: 1'b1, ex: found, id: PROC_ID_W'(pid), to: 1'b0, lat: lat});
    endtask

    // Called at a negedge; holds valid until accepted, then registers expectations.
    task automatic drive_cmd(input logic [1:0] op, input entry_t e, input bit want_rsp,
                             input logic ex, input int id, input logic to, input int lat);
        int n = 0;
        logic [3:0] s;
        i_req_valid = 1'b1;
        i_req_op    = op;
        i_req_entry = e;
        while (!o_req_ready && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_req_ready) begin
            check("accept_wait", 32'(o_req_ready), 32'd1);
            i_req_valid = 1'b0;
            return;
        end
        case (op)
            2'd0:    s = 4'b0100;
            2'd1:    s = 4'b1000;
            default: s = 4'b0010;
        endcase
        if (op != 2'd3) strb_q.push_back('{strb: s, entry: e, cyc: cyc + 1});
        if (want_rsp) rsp_q.push_back('{is_free: 1'b0, ex: ex, id: PROC_ID_W'(id), to: to, lat: lat});
        @(negedge i_clk);
        i_req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((rsp_q.size() != 0 || strb_q.size() != 0 || plan_q.size() != 0) && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        check("drain_pending", 32'(rsp_q.size() + strb_q.size() + plan_q.size()), 32'd0);
        @(negedge i_clk);
        check("ready_when_idle", 32'(o_req_ready), 32'd1);
    endtask

    // Scripted scoreboard: each strobe consumes one plan; delay 0 means never ack.
    initial begin
        plan_t p;
        i_sb_ack = 1'b0; i_sb_exists = 1'b0; i_sb_id = '0;
        forever begin
            @(negedge i_clk);
            if (!i_rst && {o_sb_write, o_sb_read, o_sb_flush, o_sb_flush_val} != 4'b0) begin
                if (plan_q.size() == 0) begin
                    check("plan_available", 32'd0, 32'd1);
                end else begin
                    p = plan_q.pop_front();
                    if (p.delay > 0) begin
                        repeat (p.delay) @(negedge i_clk);
                        i_sb_ack = 1'b1; i_sb_exists = p.ex; i_sb_id = p.id;
                        @(negedge i_clk);
                        i_sb_ack = 1'b0; i_sb_exists = 1'b0; i_sb_id = '0;
                    end
                end
            end
        end
    end

    // Monitor: compares every strobe and response against the queued expectations.
    initial begin
        logic [3:0] s;
        strb_t es;
        rsp_t  er;
        forever begin
            @(negedge i_clk);
            s = {o_sb_write, o_sb_read, o_sb_flush, o_sb_flush_val};
            if (s != 4'b0) begin
                last_strobe_cyc = cyc;
                if (strb_q.size() == 0) begin
                    check("unexpected_strobe", 32'(s), 32'd0);
                end else begin
                    es = strb_q.pop_front();
                    check("strobe_kind", 32'(s), 32'(es.strb));
                    check("strobe_entry", 32'(o_sb_entry), 32'(es.entry));
                    if (es.cyc >= 0) check("strobe_latency", 32'(cyc), 32'(es.cyc));
                end
            end
            if (o_rsp_valid || o_free_valid) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rsp", {30'd0, o_rsp_valid, o_free_valid}, 32'd0);
                end else begin
                    er = rsp_q.pop_front();
                    check("rsp_is_free", 32'(o_free_valid), 32'(er.is_free));
                    if (er.is_free) begin
                        check("free_found", 32'(o_free_found), 32'(er.ex));
                        check("free_proc_id", 32'(o_free_proc_id), 32'(er.id));
                    end else begin
                        check("rsp_exists", 32'(o_rsp_exists), 32'(er.ex));
                        check("rsp_proc_id", 32'(o_rsp_proc_id), 32'(er.id));
                        check("rsp_timeout", 32'(o_rsp_timeout), 32'(er.to));
                    end
                    if (er.lat >= 0) check("rsp_latency", 32'(cyc - last_strobe_cyc), 32'(er.lat));
                end
            end
            if (!o_rsp_valid) check("rsp_idle_zero", 32'({o_rsp_exists, o_rsp_proc_id, o_rsp_timeout}), 32'd0);
            if (!o_free_valid) check("free_idle_zero", 32'({o_free_found, o_free_proc_id}), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst = 1'b1; i_req_valid = 1'b0; i_req_op = 2'd0; i_req_entry = '0; i_proc_done = '0;
        repeat (3) @(negedge i_clk);
        check("reset_outputs", 32'({o_req_ready, o_sb_entry, o_sb_write, o_sb_read, o_sb_flush,
              o_sb_flush_val, o_rsp_valid, o_rsp_exists, o_rsp_proc_id, o_rsp_timeout,
              o_free_valid, o_free_proc_id, o_free_found}), 32'd0);
        i_rst = 1'b0;
        #1;
        check("ready_after_reset", 32'(o_req_ready), 32'd1);
        @(negedge i_clk);

        // INSERT {5,2}: scoreboard reports exists=0, INSERT still answers exists=1.
        plan(2, 1'b0, 2);
        drive_cmd(2'd1, mk(5, 2), 1'b1, 1'b1, 2, 1'b0, 3);
        wait_drain(50);

        // LOOKUP hit and miss.
        plan(3, 1'b1, 2);
        drive_cmd(2'd0, mk(5, 0), 1'b1, 1'b1, 2, 1'b0, 4);
        wait_drain(50);
        plan(2, 1'b0, 0);
        drive_cmd(2'd0, mk(9, 0), 1'b1, 1'b0, 0, 1'b0, 3);
        wait_drain(50);

        // Reserved op: immediate response, no strobe.
        drive_cmd(2'd3, mk(7, 1), 1'b1, 1'b0, 0, 1'b0, -1);
        wait_drain(20);

        // Completions 1 and 3 take priority over a waiting LOOKUP.
        exp_free(1, 1'b1, 3);
        exp_free(3, 1'b0, 5);
        plan(2, 1'b1, 0);
        plan(4, 1'b0, 0);
        plan(2, 1'b1, 3);
        i_proc_done = 4'b1010;
        @(negedge i_clk);
        i_proc_done = '0;
        drive_cmd(2'd0, mk(9, 0), 1'b1, 1'b1, 3, 1'b0, 3);
        wait_drain(100);

        // Re-pulse proc 1 on the cycle its flush_val issues: a second flush follows.
        exp_free(1, 1'b1, 4);
        exp_free(1, 1'b0, 3);
        plan(3, 1'b1, 0);
        plan(2, 1'b0, 0);
        i_proc_done = 4'b0010;
        @(negedge i_clk);
        i_proc_done = '0;
        for (int n = 0; n < 10 && !o_sb_flush_val; n++) @(negedge i_clk);
        i_proc_done = 4'b0010;
        @(negedge i_clk);
        i_proc_done = '0;
        wait_drain(100);

        // Timeout, ack on the final WAIT cycle, and a FREE that times out.
        plan(0, 1'b0, 0);
        drive_cmd(2'd2, mk(5, 0), 1'b1, 1'b0, 0, 1'b1, TIMEOUT + 1);
        wait_drain(200);
        plan(TIMEOUT, 1'b1, 2);
        drive_cmd(2'd2, mk(5, 0), 1'b1, 1'b1, 2, 1'b0, TIMEOUT + 1);
        wait_drain(200);
        exp_free(2, 1'b0, TIMEOUT + 1);
        plan(0, 1'b0, 0);
        i_proc_done = 4'b0100;
        @(negedge i_clk);
        i_proc_done = '0;
        wait_drain(200);

        // Reset during WAIT: no response, pending completion dropped, late ack ignored.
        plan(10, 1'b1, 1);
        drive_cmd(2'd2, mk(6, 0), 1'b0, 1'b0, 0, 1'b0, -1);
        @(negedge i_clk);
        i_proc_done = 4'b0001;
        @(negedge i_clk);
        i_proc_done = '0;
        i_rst = 1'b1;
        @(negedge i_clk);
        check("reset_in_wait_outputs", 32'({o_req_ready, o_sb_entry, o_sb_write, o_sb_read, o_sb_flush,
              o_sb_flush_val, o_rsp_valid, o_rsp_exists, o_rsp_proc_id, o_rsp_timeout,
              o_free_valid, o_free_proc_id, o_free_found}), 32'd0);
        i_rst = 1'b0;
        #1;
        check("ready_after_mid_reset", 32'(o_req_ready), 32'd1);
        repeat (20) @(negedge i_clk);
        wait_drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
